// File: rtl/bitorder_stream.sv
// bitorder_stream: lane-order converter that gathers LANES = WORD_W/LANE_W lanes
// into a word and re-emits them one per cycle, reversed or in arrival order.
//
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset
//   reverse_en   1 = reverse lane order within each word (latched per frame)
//   axiiv        input lane valid, gap-free for a whole frame
//   axiid        input lane data
//   axiov        output lane valid
//   axiod        output lane data, 0 whenever axiov is 0
//   axiolast     marks the final output lane of a frame
//   partial_drop pulses in the cycle a frame ends mid-word
module bitorder_stream #(
    parameter int LANE_W = 2,
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reverse_en,
    input  logic              axiiv,
    input  logic [LANE_W-1:0] axiid,
    output logic              axiov,
    output logic [LANE_W-1:0] axiod,
    output logic              axiolast,
    output logic              partial_drop
);
    localparam int LANES = WORD_W / LANE_W;
    localparam int IW = $clog2(LANES);
    localparam logic [IW-1:0] LAST = IW'(LANES - 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]        state;
    logic              ptr;
    logic              rev;
    logic              armed;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_nx;
    logic [IW-1:0]     ridx;
    logic [WORD_W-1:0] bufs [2];
    logic [WORD_W-1:0] rbuf;
    logic              fall;

    // Outputs come straight from registered state so the first lane of a word
    // is visible in the cycle right after its last lane was captured.
    always_comb begin
        idx_nx       = (idx == LAST) ? '0 : idx + 1'b1;
        rbuf         = bufs[~ptr];
        ridx         = rev ? LAST - idx : idx;
        axiov        = (state == STREAM) || (state == DRAIN);
        axiod        = axiov ? rbuf[ridx*LANE_W +: LANE_W] : '0;
        fall         = ((state == FILL) || (state == STREAM)) && !axiiv;
        axiolast     = (idx == LAST) && ((state == DRAIN) || ((state == STREAM) && fall));
        // FILL always holds idx >= 1, so a nonzero index covers both drop cases.
        partial_drop = fall && (idx != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            rev     <= 1'b0;
            armed   <= 1'b0;
            idx     <= '0;
            bufs[0] <= '0;
            bufs[1] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (armed && axiiv) begin
                        rev <= reverse_en;
                        armed <= 1'b0;
                        bufs[ptr][idx*LANE_W +: LANE_W] <= axiid;
                        idx <= idx_nx;
                        state <= FILL;
                    end else if (!axiiv) begin
                        armed <= 1'b1;
                    end
                end
                FILL: begin
                    if (!axiiv) begin
                        bufs[ptr] <= '0;
                        idx <= '0;
                        state <= IDLE;
                    end else begin
                        bufs[ptr][idx*LANE_W +: LANE_W] <= axiid;
                        idx <= idx_nx;
                        if (idx == LAST) begin
                            ptr <= ~ptr;
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (!axiiv) begin
                        bufs[ptr] <= '0;
                        idx <= idx_nx;
                        if (idx == LAST) begin
                            bufs[~ptr] <= '0;
                            state <= IDLE;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        bufs[ptr][idx*LANE_W +: LANE_W] <= axiid;
                        idx <= idx_nx;
                        // Read word done: clear it and swap roles with the fresh write word.
                        if (idx == LAST) begin
                            bufs[~ptr] <= '0;
                            ptr <= ~ptr;
                        end
                    end
                end
                default: begin
                    idx <= idx_nx;
                    if (idx == LAST) begin
                        bufs[~ptr] <= '0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
